dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 56 +++++
 rtl/dmem_arbiter.sv | 130 +++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle for the two-requester data-memory arbiter: requester ports, data-memory port and IO-window port.
// The arbiter takes the slave side; the surrounding system (or a bench) takes the master side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              rq0_req;
  logic              rq0_wr;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic              rq0_gnt;
  logic [DATA_W-1:0] rq0_rdata;
  logic              rq0_rvalid;

  logic              rq1_req;
  logic              rq1_wr;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic              rq1_gnt;
  logic [DATA_W-1:0] rq1_rdata;
  logic              rq1_rvalid;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_rdata;

  logic [2:0]        io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic              io_wr;
  logic              io_rd;
  logic [DATA_W-1:0] io_rdata;

  modport slave (
    input  rq0_req, rq0_wr, rq0_addr, rq0_wdata,
    output rq0_gnt, rq0_rdata, rq0_rvalid,
    input  rq1_req, rq1_wr, rq1_addr, rq1_wdata,
    output rq1_gnt, rq1_rdata, rq1_rvalid,
    output mem_addr, mem_wdata, mem_wr, mem_rd,
    input  mem_rdata,
    output io_addr, io_wdata, io_wr, io_rd,
    input  io_rdata
  );

  modport master (
    output rq0_req, rq0_wr, rq0_addr, rq0_wdata,
    input  rq0_gnt, rq0_rdata, rq0_rvalid,
    output rq1_req, rq1_wr, rq1_addr, rq1_wdata,
    input  rq1_gnt, rq1_rdata, rq1_rvalid,
    input  mem_addr, mem_wdata, mem_wr, mem_rd,
    output mem_rdata,
    input  io_addr, io_wdata, io_wr, io_rd,
    output io_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a shared data-memory / IO port: registered grants, round-robin on contention
// with a bounded hold, address decode into memory (rebased) or IO window, one-cycle read return.
module dmem_arbiter #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 8,
  parameter int MEM_BASE = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} owner_t;

  owner_t            owner_reg, owner_next;
  logic              last_owner_reg, last_owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [1:0]        rvalid_reg;
  logic              region_mem_reg;

  logic [1:0]        req, wr, gnt, issue;
  logic [ADDR_W-1:0] addr [2];
  logic [DATA_W-1:0] wdata [2];
  logic [DATA_W-1:0] rdata [2];
  logic              cur_idx, oth_idx;

  logic              any_issue, sel, in_mem;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel, rd_mux;

  assign req      = {bus.rq1_req, bus.rq0_req};
  assign wr       = {bus.rq1_wr, bus.rq0_wr};
  assign addr[0]  = bus.rq0_addr;
  assign addr[1]  = bus.rq1_addr;
  assign wdata[0] = bus.rq0_wdata;
  assign wdata[1] = bus.rq1_wdata;

  // Grants and read returns come straight from registers, so reset clears them without a clock edge.
  assign rd_mux = region_mem_reg ? bus.mem_rdata : bus.io_rdata;
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign gnt[gi]   = (owner_reg == ((gi == 0) ? OWN0 : OWN1));
      assign issue[gi] = gnt[gi] & req[gi];
      assign rdata[gi] = rvalid_reg[gi] ? rd_mux : '0;
    end
  endgenerate

  assign bus.rq0_gnt    = gnt[0];
  assign bus.rq1_gnt    = gnt[1];
  assign bus.rq0_rvalid = rvalid_reg[0];
  assign bus.rq1_rvalid = rvalid_reg[1];
  assign bus.rq0_rdata  = rdata[0];
  assign bus.rq1_rdata  = rdata[1];

  // Grants are mutually exclusive, so the issuing requester is identified by issue[1] alone.
  assign any_issue = |issue;
  assign sel       = issue[1];
  assign addr_sel  = addr[sel];
  assign wdata_sel = wdata[sel];
  assign in_mem    = (addr_sel >= ADDR_W'(MEM_BASE));

  assign bus.mem_addr  = (any_issue && in_mem)  ? addr_sel - ADDR_W'(MEM_BASE) : '0;
  assign bus.mem_wdata = (any_issue && in_mem)  ? wdata_sel : '0;
  assign bus.mem_wr    = any_issue && in_mem && wr[sel];
  assign bus.mem_rd    = any_issue && in_mem && !wr[sel];
  assign bus.io_addr   = (any_issue && !in_mem) ? addr_sel[2:0] : '0;
  assign bus.io_wdata  = (any_issue && !in_mem) ? wdata_sel : '0;
  assign bus.io_wr     = any_issue && !in_mem && wr[sel];
  assign bus.io_rd     = any_issue && !in_mem && !wr[sel];

  always_comb begin
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    hold_cnt_next   = hold_cnt_reg;
    cur_idx         = (owner_reg == OWN1);
    oth_idx         = (owner_reg != OWN1);
    case (owner_reg)
      IDLE: begin
        if (req[0] && req[1]) begin
          owner_next    = last_owner_reg ? OWN0 : OWN1;
          hold_cnt_next = HOLD_W'(1);
        end else if (req[0]) begin
          owner_next    = OWN0;
          hold_cnt_next = HOLD_W'(1);
        end else if (req[1]) begin
          owner_next    = OWN1;
          hold_cnt_next = HOLD_W'(1);
        end
      end
      OWN0, OWN1: begin
        if (!req[cur_idx]) begin
          last_owner_next = cur_idx;
          if (req[oth_idx]) begin
            owner_next    = oth_idx ? OWN1 : OWN0;
            hold_cnt_next = HOLD_W'(1);
          end else begin
            owner_next    = IDLE;
            hold_cnt_next = '0;
          end
        end else if (req[oth_idx] && hold_cnt_reg == HOLD_W'(MAX_HOLD)) begin
          // Hold budget spent with the other side waiting: hand over without an idle cycle.
          owner_next      = oth_idx ? OWN1 : OWN0;
          hold_cnt_next   = HOLD_W'(1);
          last_owner_next = cur_idx;
        end else if (hold_cnt_reg != HOLD_W'(MAX_HOLD)) begin
          hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
        end
      end
      default: owner_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_reg      <= IDLE;
      last_owner_reg <= 1'b1;
      hold_cnt_reg   <= '0;
      rvalid_reg     <= '0;
      region_mem_reg <= 1'b0;
    end else begin
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      hold_cnt_reg   <= hold_cnt_next;
      rvalid_reg     <= issue & ~wr;
      if (any_issue) region_mem_reg <= in_mem;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers queue expected accesses, a negedge monitor checks the
// shared bus, read returns and grant exclusivity against a spec-level decode model.
module tb_dmem_arbiter;
  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 8;
  localparam int MEM_BASE = 8;
  localparam int MAX_HOLD = 4;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_BASE(MEM_BASE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  txn_t exp_q0[$];
  txn_t exp_q1[$];
  txn_t stream_txn [2];
  logic [1:0] stream_mode = 2'b00;
  logic [1:0] exp_rv = 2'b00;
  logic       exp_mem = 1'b0;
  bit         rand_data = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [33:0] bus_now();
    return {bus.mem_addr, bus.mem_wdata, bus.mem_wr, bus.mem_rd,
            bus.io_addr, bus.io_wdata, bus.io_wr, bus.io_rd};
  endfunction

  // Expected shared-bus outputs for one access (or none), straight from the address map.
  function automatic logic [33:0] bus_exp(input logic any, input txn_t t);
    logic [ADDR_W-1:0] ma;
    if (!any) return '0;
    if (t.addr >= ADDR_W'(MEM_BASE)) begin
      ma = t.addr - ADDR_W'(MEM_BASE);
      return {ma, t.wdata, t.wr, !t.wr, 3'b000, 8'h00, 2'b00};
    end
    return {11'h000, 8'h00, 2'b00, t.addr[2:0], t.wdata, t.wr, !t.wr};
  endfunction

  function automatic logic gnt_of(input int n);
    return (n == 0) ? bus.rq0_gnt : bus.rq1_gnt;
  endfunction

  task automatic set_req(input int n, input logic r, input txn_t t);
    if (n == 0) begin
      bus.rq0_req = r; bus.rq0_wr = t.wr; bus.rq0_addr = t.addr; bus.rq0_wdata = t.wdata;
    end else begin
      bus.rq1_req = r; bus.rq1_wr = t.wr; bus.rq1_addr = t.addr; bus.rq1_wdata = t.wdata;
    end
  endtask

  // One transaction: raise request, hold until granted, drop. lat = negedges seen without grant.
  task automatic drive(input int n, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, output int lat);
    txn_t t;
    t = {wr, addr, wd};
    @(posedge clk); #1;
    if (n == 0) exp_q0.push_back(t); else exp_q1.push_back(t);
    set_req(n, 1'b1, t);
    lat = 0;
    forever begin
      @(negedge clk);
      if (gnt_of(n)) break;
      lat++;
      if (lat > 40) begin
        check($sformatf("rq%0d_grant_timeout", n), 64'(lat), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    set_req(n, 1'b0, '0);
  endtask

  // Read data sources; randomised per cycle in the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_data) begin
      bus.mem_rdata = 8'($urandom);
      bus.io_rdata  = 8'($urandom);
    end else begin
      bus.mem_rdata = 8'h5A;
      bus.io_rdata  = 8'hC3;
    end
  end

  always @(negedge clk) begin : monitor
    txn_t       t;
    logic [1:0] iss;
    logic [1:0] nrv;
    logic       nmem;
    if (reset) begin
      check("reset_outputs", {bus.rq0_gnt, bus.rq1_gnt, bus.rq0_rvalid, bus.rq1_rvalid,
                              bus.rq0_rdata, bus.rq1_rdata, bus_now()}, 64'd0);
      exp_rv = 2'b00;
    end else begin
      check("gnt_exclusive", 64'(bus.rq0_gnt & bus.rq1_gnt), 64'd0);
      check("rq0_rvalid", 64'(bus.rq0_rvalid), 64'(exp_rv[0]));
      if (exp_rv[0]) check("rq0_rdata", 64'(bus.rq0_rdata), 64'(exp_mem ? bus.mem_rdata : bus.io_rdata));
      check("rq1_rvalid", 64'(bus.rq1_rvalid), 64'(exp_rv[1]));
      if (exp_rv[1]) check("rq1_rdata", 64'(bus.rq1_rdata), 64'(exp_mem ? bus.mem_rdata : bus.io_rdata));
      iss  = {bus.rq1_gnt & bus.rq1_req, bus.rq0_gnt & bus.rq0_req};
      t    = '0;
      nrv  = 2'b00;
      nmem = 1'b0;
      for (int n = 0; n < 2; n++) begin
        if (iss[n]) begin
          if (stream_mode[n]) t = stream_txn[n];
          else if (n == 0 && exp_q0.size() == 0) check("rq0_unexpected_access", 64'd1, 64'd0);
          else if (n == 1 && exp_q1.size() == 0) check("rq1_unexpected_access", 64'd1, 64'd0);
          else if (n == 0) t = exp_q0.pop_front();
          else t = exp_q1.pop_front();
          nrv[n] = !t.wr;
          nmem   = (t.addr >= ADDR_W'(MEM_BASE));
        end
      end
      check("bus_outputs", 64'(bus_now()), 64'(bus_exp(|iss, t)));
      exp_rv  = nrv;
      exp_mem = nmem;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int lat;
    int w;
    logic [ADDR_W-1:0] dir_addr [6];
    logic              dir_wr   [6];
    dir_addr = '{11'd7, 11'd2047, 11'd0, 11'd9, 11'd8, 11'd1024};
    dir_wr   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    reset = 1'b1;
    set_req(0, 1'b0, '0);
    set_req(1, 1'b0, '0);
    bus.mem_rdata = 8'h5A;
    bus.io_rdata  = 8'hC3;
    stream_txn[0] = '0;
    stream_txn[1] = '0;
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Memory read, memory write, IO read, each from idle: grant one cycle after request.
    drive(0, 1'b0, 11'd8, 8'h00, lat);
    check("rd8_latency", 64'(lat), 64'd1);
    repeat (3) @(posedge clk);
    drive(1, 1'b1, 11'd15, 8'h01, lat);
    check("wr15_latency", 64'(lat), 64'd1);
    repeat (3) @(posedge clk);
    drive(0, 1'b0, 11'd3, 8'h00, lat);
    check("io3_latency", 64'(lat), 64'd1);
    for (int i = 0; i < 6; i++) begin
      repeat (2) @(posedge clk);
      drive(i % 2, dir_wr[i], dir_addr[i], 8'(8'h30 + i), lat);
    end
    repeat (3) @(posedge clk);

    // Both held continuously from reset: 4 grants each, alternating, starting with rq0.
    @(negedge clk); #1 reset = 1'b1;
    @(negedge clk); #1 reset = 1'b0;
    stream_txn[0] = {1'b0, 11'd20, 8'h00};
    stream_txn[1] = {1'b1, 11'd2, 8'h77};
    stream_mode   = 2'b11;
    @(posedge clk); #1;
    set_req(0, 1'b1, stream_txn[0]);
    set_req(1, 1'b1, stream_txn[1]);
    @(negedge clk);
    check("hold_first_cycle_no_gnt", 64'({bus.rq0_gnt, bus.rq1_gnt}), 64'd0);
    for (int i = 0; i < 4 * MAX_HOLD; i++) begin
      @(negedge clk);
      check($sformatf("hold_gnt0_c%0d", i), 64'(bus.rq0_gnt), 64'(((i / MAX_HOLD) % 2) == 0));
      check($sformatf("hold_gnt1_c%0d", i), 64'(bus.rq1_gnt), 64'(((i / MAX_HOLD) % 2) == 1));
    end

    // rq0 drops mid-ownership: rq1 takes over with no idle cycle.
    w = 0;
    while (!bus.rq0_gnt && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("wait_gnt0", 64'(bus.rq0_gnt), 64'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, '0);
    @(negedge clk);
    check("drop_gnt0_still_owner", 64'({bus.rq0_gnt, bus.rq1_gnt}), 64'b10);
    @(negedge clk);
    check("handover_to_rq1", 64'({bus.rq0_gnt, bus.rq1_gnt}), 64'b01);
    @(posedge clk); #1;
    set_req(1, 1'b0, '0);
    repeat (3) @(posedge clk);

    // Reset asserted in the cycle a read issues: outputs clear at once, read is dropped.
    stream_txn[0] = {1'b0, 11'd9, 8'h00};
    stream_mode   = 2'b01;
    @(posedge clk); #1;
    set_req(0, 1'b1, stream_txn[0]);
    w = 0;
    while (!bus.rq0_gnt && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("rst_wait_gnt0", 64'(bus.rq0_gnt), 64'd1);
    #1 reset = 1'b1;
    set_req(0, 1'b0, '0);
    #1;
    check("async_reset_outputs", {10'd0, bus.rq0_gnt, bus.rq1_gnt, bus.rq0_rvalid, bus.rq1_rvalid,
                                  bus.rq0_rdata, bus.rq1_rdata, bus_now()}, 64'd0);
    @(negedge clk); #1 reset = 1'b0;
    stream_mode = 2'b00;
    repeat (3) @(negedge clk);
    drive(0, 1'b0, 11'd9, 8'h00, lat);
    check("post_reset_latency", 64'(lat), 64'd1);
    repeat (3) @(posedge clk);

    // Random traffic from both requesters concurrently.
    rand_data = 1'b1;
    fork
      begin
        int lat0;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          drive(0, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), lat0);
          check("rq0_rand_latency_bound", 64'(lat0 > MAX_HOLD + 1), 64'd0);
        end
      end
      begin
        int lat1;
        for (int k = 0; k < 40; k++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          drive(1, 1'($urandom), ADDR_W'($urandom), DATA_W'($urandom), lat1);
          check("rq1_rand_latency_bound", 64'(lat1 > MAX_HOLD + 1), 64'd0);
        end
      end
    join
    repeat (5) @(negedge clk);
    check("rq0_queue_drained", 64'(exp_q0.size()), 64'd0);
    check("rq1_queue_drained", 64'(exp_q1.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
